// File: rtl/autobaud_ctrl.sv
// Autobaud divisor controller: measures a 0x55 sync character on rx and derives the
// tick-generator divisor, with a manual override path from software.
module autobaud_ctrl #(
  parameter int DIV_BITS    = 10,
  parameter int DEFAULT_DIV = 650
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                rx,
  input  logic                start,
  input  logic                manual_we,
  input  logic [DIV_BITS-1:0] manual_div,
  output logic [DIV_BITS-1:0] ticks,
  output logic                busy,
  output logic                locked,
  output logic                err
);

  localparam int CNT_BITS = DIV_BITS + 7;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] MEASURE = 2'd2;
  localparam logic [1:0] COMMIT  = 2'd3;

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [DIV_BITS:0]   Q_MIN   = (DIV_BITS+1)'(2);
  localparam logic [DIV_BITS:0]   Q_MAX   = (DIV_BITS+1)'(1) << DIV_BITS;

  logic                rx_meta;
  logic                rx_sync;
  logic                rx_prev;
  logic                fe;
  logic [1:0]          state;
  logic [CNT_BITS-1:0] cnt;
  logic [CNT_BITS-1:0] cap;
  logic [2:0]          edges;
  logic [DIV_BITS:0]   q;
  logic                q_ok;

  assign fe   = rx_prev & ~rx_sync;
  assign busy = (state == ARMED) || (state == MEASURE);

  // Round C/128 to nearest: one tick period spans 1/16 of a bit, and C covers 8 bits.
  assign q    = (DIV_BITS+1)'(({1'b0, cap} + (CNT_BITS+1)'(64)) >> 7);
  assign q_ok = (q >= Q_MIN) && (q <= Q_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      state   <= IDLE;
      cnt     <= '0;
      cap     <= '0;
      edges   <= '0;
      ticks   <= DIV_BITS'(DEFAULT_DIV);
      locked  <= 1'b0;
      err     <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;

      if (manual_we) begin
        ticks  <= manual_div;
        locked <= 1'b1;
        err    <= 1'b0;
        state  <= IDLE;
        cnt    <= '0;
        edges  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state  <= ARMED;
              locked <= 1'b0;
              err    <= 1'b0;
            end
          end
          ARMED: begin
            if (fe) begin
              state <= MEASURE;
              cnt   <= '0;
              edges <= 3'd1;
            end
          end
          MEASURE: begin
            // A saturated counter means the line went quiet mid-character.
            if (cnt == CNT_MAX) begin
              err   <= 1'b1;
              state <= IDLE;
            end else if (fe && (edges == 3'd4)) begin
              cap   <= cnt + CNT_BITS'(1);
              state <= COMMIT;
            end else begin
              cnt <= cnt + CNT_BITS'(1);
              if (fe) begin
                edges <= edges + 3'd1;
              end
            end
          end
          COMMIT: begin
            if (q_ok) begin
              ticks  <= DIV_BITS'(q - (DIV_BITS+1)'(1));
              locked <= 1'b1;
            end else begin
              err <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/autobaud_ctrl.md
AUTOBAUD_CTRL -- requirements
Module: autobaud_ctrl

Interface
REQ-001 SHALL have parameter DIV_BITS, default 10, width of the divisor driven to the baud tick generator.
REQ-002 SHALL have parameter DEFAULT_DIV, default 650, divisor value loaded at reset.
REQ-003 SHALL have derived localparam CNT_BITS = DIV_BITS+7, width of the measurement counter.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port start  input  1  single-cycle pulse that arms autobaud detection.
REQ-008 SHALL have port manual_we  input  1  single-cycle pulse that loads manual_div.
REQ-009 SHALL have port manual_div  input  DIV_BITS  software divisor.
REQ-010 SHALL have port ticks  output  DIV_BITS  registered divisor to tick generator (tick period = ticks+1 clk).
REQ-011 SHALL have port busy  output  1  high in ARMED or MEASURE.
REQ-012 SHALL have port locked  output  1  divisor valid from autobaud or manual load.
REQ-013 SHALL have port err  output  1  sticky failure flag.

Function
REQ-014 SHALL synchronize rx through two flops; a falling edge (fe) is sync'd rx 1->0 between consecutive cycles, using a third flop.
REQ-015 SHALL implement FSM states IDLE, ARMED, MEASURE, COMMIT.
REQ-016 IDLE: start -> ARMED; locked and err cleared in the cycle after start.
REQ-017 ARMED: on fe -> MEASURE, counter cleared to 0, edge count set to 1.
REQ-018 MEASURE: counter increments by 1 per cycle; each fe increments edge count; on 5th fe capture counter+1 as C and -> COMMIT (C = cycles spanning 8 bit periods of sync char 0x55).
REQ-019 COMMIT: compute Q = (C+64)>>7; if 2 <= Q <= 2^DIV_BITS, ticks <= Q-1, locked <= 1; else err <= 1, ticks unchanged; -> IDLE.
REQ-020 Latency: ticks/locked update exactly 1 cycle after the cycle in which the 5th fe is detected.
REQ-021 Counter SHALL saturate at all-ones; reaching all-ones in MEASURE sets err and returns to IDLE (timeout); no wrap-around.
REQ-022 ARMED waits indefinitely for fe; no timeout before the first edge.
REQ-023 start while busy or in COMMIT SHALL be ignored.
REQ-024 manual_we in any state SHALL: ticks <= manual_div, locked <= 1, err <= 0, abort any measurement, -> IDLE, all next cycle.
REQ-025 manual_we and start in same cycle: manual_we wins, start ignored.
REQ-026 manual_div = 0 SHALL be accepted as-is (no range check on manual path).
REQ-027 ticks SHALL change only on COMMIT success or manual_we; never glitch mid-measurement.

Reset
REQ-028 reset_n low SHALL asynchronously force: state IDLE, ticks = DEFAULT_DIV, busy 0, locked 0, err 0, counters 0, synchronizer flops 1.
REQ-029 Reset mid-measurement SHALL discard the measurement; no partial ticks update.

Verification
REQ-030 Reset: assert reset_n low mid-MEASURE -> ticks=650, locked=0, err=0, busy=0 immediately.
REQ-031 Autobaud: start, then 0x55 frame at 160 clk/bit -> C=1280, Q=10, ticks=9, locked=1, 1 cycle after 5th fe.
REQ-032 Too fast: start, 0x55 at 8 clk/bit -> C=64, Q=1 -> err=1, ticks unchanged, locked=0.
REQ-033 Timeout: start, single fe then rx held high > 2^17 cycles -> err=1, state IDLE, ticks unchanged.
REQ-034 Manual: manual_we with manual_div=651 same cycle as start -> ticks=651, locked=1, busy=0, start ignored.
REQ-035 Abort: manual_we=1, manual_div=100 after 3rd fe -> ticks=100, busy=0; later fe pulses cause no update.
